// File: rtl/uart_move_cmd_queue.sv
// Decodes UART bytes into cube move commands, queues them, and expands each
// command's repeat count into single-move valid/ready requests for the sequencer.
module uart_move_cmd_queue #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              I_sys_clk,
  input  logic              I_on_board_reset_n,
  input  logic [7:0]        I_rx_byte,
  input  logic              I_rx_byte_valid,
  input  logic              I_rx_frame_err,
  input  logic              I_clear_err,
  input  logic              I_cmd_ready,
  output logic              o_cmd_valid,
  output logic [1:0]        o_cmd_row,
  output logic              o_cmd_dir,
  output logic              o_cmd_release,
  output logic [ADDR_W:0]   o_fifo_count,
  output logic              o_fifo_full,
  output logic              o_overflow,
  output logic              o_reject,
  output logic [6:0]        debug_led
);

  typedef enum logic {IDLE, ISSUE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(FIFO_DEPTH);

  logic [7:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [3:0]        rep_cnt;
  logic [7:0]        head;
  state_t            state;
  state_t            state_nxt;

  logic byte_bad;
  logic byte_good;
  logic push;
  logic pop;
  logic fifo_empty;
  logic hs;
  logic last_move;

  assign byte_bad   = I_rx_byte_valid & (I_rx_frame_err | (I_rx_byte[3:0] == 4'd0));
  assign byte_good  = I_rx_byte_valid & ~I_rx_frame_err & (I_rx_byte[3:0] != 4'd0);
  assign push       = byte_good & ~o_fifo_full;
  assign fifo_empty = (o_fifo_count == '0);
  assign hs         = o_cmd_valid & I_cmd_ready;
  assign last_move  = hs & (rep_cnt == 4'd1);
  // Pop from IDLE, or chain straight into the next command on the last move (no bubble).
  assign pop        = ~fifo_empty & ((state == IDLE) | last_move);
  assign head       = mem[rd_ptr];
  assign o_fifo_full = (o_fifo_count == DEPTH_C);
  assign debug_led  = {o_reject, o_overflow, o_fifo_full, o_cmd_valid, o_cmd_dir, o_cmd_row};

  always_ff @(posedge I_sys_clk) begin
    if (push) mem[wr_ptr] <= I_rx_byte;
  end

  always_ff @(posedge I_sys_clk or negedge I_on_board_reset_n) begin
    if (!I_on_board_reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      o_fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   o_fifo_count <= o_fifo_count + (ADDR_W+1)'(1);
        2'b01:   o_fifo_count <= o_fifo_count - (ADDR_W+1)'(1);
        default: o_fifo_count <= o_fifo_count;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge I_sys_clk or negedge I_on_board_reset_n) begin
    if (!I_on_board_reset_n) state <= IDLE;
    else                     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:   if (last_move && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_cmd_valid = (state == ISSUE);
  end

  always_ff @(posedge I_sys_clk or negedge I_on_board_reset_n) begin
    if (!I_on_board_reset_n) begin
      o_cmd_row     <= '0;
      o_cmd_dir     <= 1'b0;
      o_cmd_release <= 1'b0;
      rep_cnt       <= '0;
    end else if (pop) begin
      {o_cmd_row, o_cmd_dir, o_cmd_release} <= head[7:4];
      rep_cnt <= head[3:0];
    end else if (hs) begin
      rep_cnt <= rep_cnt - 4'd1;
    end
  end

  // Sticky errors: a new error in the same cycle as a clear wins.
  always_ff @(posedge I_sys_clk or negedge I_on_board_reset_n) begin
    if (!I_on_board_reset_n) begin
      o_overflow <= 1'b0;
      o_reject   <= 1'b0;
    end else begin
      if (byte_good && o_fifo_full) o_overflow <= 1'b1;
      else if (I_clear_err)         o_overflow <= 1'b0;
      if (byte_bad)                 o_reject   <= 1'b1;
      else if (I_clear_err)         o_reject   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_move_cmd_queue.sv
// Directed bench for uart_move_cmd_queue: hand-computed expectations checked
// with immediate assertions after each clock edge.
`timescale 1ns/1ps
module tb_uart_move_cmd_queue;

  logic       I_sys_clk_tb;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_vld;
  logic       frame_err;
  logic       clear_err;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_row;
  logic       cmd_dir;
  logic       cmd_release;
  logic [3:0] fifo_count;
  logic       fifo_full;
  logic       overflow;
  logic       reject;
  logic [6:0] debug_led;
  logic [3:0] fields;

  int total = 0;
  int bad   = 0;

  assign fields = {cmd_row, cmd_dir, cmd_release};

  uart_move_cmd_queue #(.FIFO_DEPTH(8), .ADDR_W(3)) dut (
    .I_sys_clk          (I_sys_clk_tb),
    .I_on_board_reset_n (rst_n),
    .I_rx_byte          (rx_byte),
    .I_rx_byte_valid    (rx_vld),
    .I_rx_frame_err     (frame_err),
    .I_clear_err        (clear_err),
    .I_cmd_ready        (cmd_ready),
    .o_cmd_valid        (cmd_valid),
    .o_cmd_row          (cmd_row),
    .o_cmd_dir          (cmd_dir),
    .o_cmd_release      (cmd_release),
    .o_fifo_count       (fifo_count),
    .o_fifo_full        (fifo_full),
    .o_overflow         (overflow),
    .o_reject           (reject),
    .debug_led          (debug_led)
  );

  initial I_sys_clk_tb = 1'b0;
  always #5 I_sys_clk_tb = ~I_sys_clk_tb;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge I_sys_clk_tb);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic fe);
    rx_byte   = b;
    rx_vld    = 1'b1;
    frame_err = fe;
    tick();
    rx_vld    = 1'b0;
    frame_err = 1'b0;
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  initial begin
    int n;
    int got;
    int gaps;
    int k;
    int maxc;
    logic       prev_hold;
    logic [3:0] prev_f;
    logic [3:0] mv [3];
    logic [3:0] expf [20];
    logic [7:0] b5;

    rst_n = 1'b0; rx_byte = '0; rx_vld = 1'b0; frame_err = 1'b0;
    clear_err = 1'b0; cmd_ready = 1'b0;
    repeat (2) tick();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_led", debug_led, 0);
    chk("rst_flags", {fifo_full, overflow, reject}, 0);
    rst_n = 1'b1;
    tick();

    // 0x77: row 01, cw, release, 7 repeats
    cmd_ready = 1'b1;
    send(8'h77, 1'b0);
    chk("t1_count_after_write", fifo_count, 1);
    chk("t1_valid_not_yet", cmd_valid, 0);
    tick();
    n = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 0) chk("t1_led", debug_led, 7'b0001101);
      if (cmd_valid && fields == 4'b0111) n++;
      tick();
    end
    chk("t1_moves", n, 7);
    chk("t1_valid_low_after", cmd_valid, 0);
    chk("t1_count_end", fifo_count, 0);

    // Malformed bytes
    send(8'h70, 1'b0);
    chk("t2_reject_n0", reject, 1);
    chk("t2_count_n0", fifo_count, 0);
    pulse_clear();
    chk("t2_clear1", reject, 0);
    send(8'h85, 1'b1);
    chk("t2_reject_fe", reject, 1);
    chk("t2_led6", debug_led[6], 1);
    repeat (3) tick();
    chk("t2_no_valid", cmd_valid, 0);
    chk("t2_count_fe", fifo_count, 0);
    pulse_clear();
    chk("t2_clear2", reject, 0);
    clear_err = 1'b1;
    send(8'h85, 1'b1);
    clear_err = 1'b0;
    chk("t2_set_wins", reject, 1);
    pulse_clear();
    chk("t2_clear3", reject, 0);

    // Fill with ready low: one held on outputs plus 8 queued, the next is dropped
    cmd_ready = 1'b0;
    for (int i = 0; i < 9; i++) send(8'h41, 1'b0);
    chk("t3_count_full", fifo_count, 8);
    chk("t3_full", fifo_full, 1);
    chk("t3_led4", debug_led[4], 1);
    chk("t3_no_ovf_yet", overflow, 0);
    chk("t3_held", {cmd_valid, fields}, 5'b10100);
    send(8'h41, 1'b0);
    chk("t3_overflow", overflow, 1);
    chk("t3_led5", debug_led[5], 1);
    chk("t3_count_still8", fifo_count, 8);
    cmd_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (cmd_valid) n++;
      tick();
    end
    chk("t3_moves", n, 9);
    chk("t3_count_end", fifo_count, 0);
    pulse_clear();
    chk("t3_ovf_cleared", overflow, 0);

    // Back-to-back commands with ready toggling
    cmd_ready = 1'b0;
    send(8'hC2, 1'b0);
    send(8'h21, 1'b0);
    chk("t4_valid_start", cmd_valid, 1);
    got = 0; gaps = 0; prev_hold = 1'b0; prev_f = '0;
    for (int i = 0; i < 20; i++) begin
      if (prev_hold) chk("t4_hold", {cmd_valid, fields}, {1'b1, prev_f});
      prev_hold = cmd_valid && !cmd_ready;
      prev_f    = fields;
      if (cmd_valid && cmd_ready) begin
        if (got < 3) mv[got] = fields;
        got++;
      end else if (!cmd_valid && got < 3) begin
        gaps++;
      end
      tick();
      cmd_ready = ~cmd_ready;
    end
    chk("t4_moves", got, 3);
    chk("t4_gaps", gaps, 0);
    chk("t4_mv0", mv[0], 4'b1100);
    chk("t4_mv1", mv[1], 4'b1100);
    chk("t4_mv2", mv[2], 4'b0010);

    // Pointer wrap: 20 commands fed while draining at half rate
    for (int i = 0; i < 20; i++) begin
      logic [4:0] kk;
      kk = 5'(i);
      expf[i] = {kk[1:0], kk[2], kk[3]};
    end
    k = 0; got = 0; maxc = 0;
    for (int i = 0; i < 90; i++) begin
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      if (cmd_valid && cmd_ready) begin
        if (got < 20) chk("t5_order", fields, expf[got]);
        got++;
      end
      cmd_ready = i[0];
      if (k < 20 && (i % 3) != 2) begin
        b5 = {expf[k], 4'd1};
        rx_byte = b5;
        rx_vld  = 1'b1;
        k++;
      end else begin
        rx_vld = 1'b0;
      end
      tick();
    end
    rx_vld = 1'b0;
    chk("t5_delivered", got, 20);
    chk("t5_max_le8", (maxc <= 8), 1);
    chk("t5_backlog_seen", (maxc >= 2), 1);
    chk("t5_no_ovf", overflow, 0);

    // Reset in the middle of a command
    cmd_ready = 1'b1;
    send(8'h7F, 1'b0);
    repeat (3) tick();
    chk("t6_pre_valid", {cmd_valid, fields}, 5'b10111);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", cmd_valid, 0);
    chk("t6_rst_led", debug_led, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_fields", fields, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_after_rst_valid", cmd_valid, 0);
    send(8'h11, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid) begin
        n++;
        chk("t6_fields", fields, 4'b0001);
      end
      tick();
    end
    chk("t6_moves", n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
